// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg_if
// Purpose  : Bundles the UART receiver line input and received-word outputs.
//            master = receiver side, slave = line driver / word consumer.
//            Optional brk signal present when UART_RX_BREAK_DETECT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
  parameter int DW = 8
);
  logic          in;
  logic [DW-1:0] out;
  logic          clk_out;
  logic          perr;
  logic          ferr;
`ifdef UART_RX_BREAK_DETECT_EN
  logic          brk;

  modport master (input in, output out, output clk_out, output perr, output ferr, output brk);
  modport slave  (output in, input out, input clk_out, input perr, input ferr, input brk);
`else
  modport master (input in, output out, output clk_out, output perr, output ferr);
  modport slave  (output in, input out, input clk_out, input perr, input ferr);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised oversampling UART receiver (data width, parity,
//            stop bits, oversampling factor) with parity/framing error flags.
//            Optional break detection: define UART_RX_BREAK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int O      = 8,
  parameter int DW     = 8,
  parameter int PARITY = 0,
  parameter int SB     = 1
) (
  input wire            clk,
  input wire            rst_n,
  uart_rx_cfg_if.master bus
);
  localparam int c_OSC_W = $clog2(O);
  localparam int c_OSB_W = $clog2(O + 1);
  localparam int c_BIT_W = $clog2(DW);
  localparam logic [c_OSC_W-1:0] c_OSC_LAST = c_OSC_W'(O - 1);
  localparam logic [c_OSC_W-1:0] c_OSC_HALF = c_OSC_W'(O / 2);
  localparam logic [c_OSB_W:0]   c_MAJ      = (c_OSB_W + 1)'(O / 2);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4
`ifdef UART_RX_BREAK_DETECT_EN
    , S_BRKWAIT = 3'd5
`endif
  } state_t;

  logic               r_sync1, r_sync2;
  logic               w_s;
  state_t             r_state, w_state_nxt;
  logic [c_OSC_W-1:0] r_osc;
  logic [c_OSB_W-1:0] r_osb;
  logic [c_OSB_W:0]   w_sum;
  logic               w_tick, w_bit, w_last_bit, w_final_stop, w_sample_final;
  logic [DW-1:0]      r_shift;
  logic [c_BIT_W-1:0] r_bitcnt;
  logic               r_stopcnt;
  logic               r_perr_int, r_ferr_int, w_pcalc;
  logic [DW-1:0]      r_out;
  logic               r_clk_out, r_perr, r_ferr;

  assign w_s          = r_sync2;
  assign w_tick       = (r_osc == c_OSC_LAST);
  // Majority over the whole bit; the current sample is folded in at decision time.
  assign w_sum        = {1'b0, r_osb} + {{c_OSB_W{1'b0}}, w_s};
  assign w_bit        = (w_sum > c_MAJ);
  assign w_last_bit   = (r_bitcnt == c_BIT_LAST);
  assign w_final_stop = (SB == 1) ? 1'b1 : r_stopcnt;
  assign w_pcalc      = (^r_shift) ^ w_bit;

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_allzero, r_brk, w_brk_frame;
  // With two stop bits, ferr_int at the final sample reflects only the first one.
  assign w_brk_frame = r_allzero & ((SB == 1) ? ~w_s : r_ferr_int);
`endif

  // Two-flop synchroniser for the asynchronous line, idle-high preset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.in;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the final stop-sample strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_sample_final = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_s) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && w_last_bit) w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_tick) w_state_nxt = S_STOP;
      S_STOP: begin
        // The last stop bit is a single mid-bit sample so the next start is not missed.
        if (w_final_stop && (r_osc == c_OSC_HALF)) begin
          w_sample_final = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          w_state_nxt    = w_brk_frame ? S_BRKWAIT : S_IDLE;
`else
          w_state_nxt    = S_IDLE;
`endif
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BRKWAIT: if (w_s && w_tick) w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample counter and ones counter; BRKWAIT reuses osc to count idle-high cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_osc <= '0;
      r_osb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_osc <= c_OSC_W'(1);
          r_osb <= '0;
        end
`ifdef UART_RX_BREAK_DETECT_EN
        S_BRKWAIT: begin
          r_osb <= '0;
          if (!w_s) r_osc <= '0;
          else      r_osc <= r_osc + 1'b1;
        end
`endif
        default: begin
          if (w_tick || w_sample_final) begin
            r_osc <= '0;
            r_osb <= '0;
          end else begin
            r_osc <= r_osc + 1'b1;
            r_osb <= r_osb + c_OSB_W'(w_s);
          end
        end
      endcase
    end
  end

  // Frame datapath: shift register, bit/stop counters, latched error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_stopcnt  <= 1'b0;
      r_perr_int <= 1'b0;
      r_ferr_int <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_s) begin
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift  <= {w_bit, r_shift[DW-1:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        S_PAR: begin
          if (w_tick) r_perr_int <= (PARITY == 1) ? ~w_pcalc : w_pcalc;
        end
        S_STOP: begin
          if (w_tick && !w_final_stop) begin
            r_stopcnt <= 1'b1;
            if (!w_bit) r_ferr_int <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, updated together with the one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_clk_out <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_clk_out <= w_sample_final;
      if (w_sample_final) begin
        r_out  <= r_shift;
        r_perr <= r_perr_int;
        r_ferr <= r_ferr_int | ~w_s;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // Tracks whether every data/parity bit of the current frame decided 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_allzero <= 1'b0;
    else if ((r_state == S_IDLE) && !w_s)         r_allzero <= 1'b1;
    else if (((r_state == S_DATA) || (r_state == S_PAR)) && w_tick && w_bit)
                                                  r_allzero <= 1'b0;
  end

  // Break flag follows each strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_brk <= 1'b0;
    else if (w_sample_final) r_brk <= w_brk_frame;
  end

  assign bus.brk = r_brk;
`endif

  assign bus.out     = r_out;
  assign bus.clk_out = r_clk_out;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8n1 receiver. Supports configurable data width, parity mode, stop-bit count and oversampling factor, and flags parity and framing errors. It sits between a physical RX pin and byte-consuming logic such as FIFOs or command decoders. Unbuffered: each received word is presented once, with a one-cycle strobe.

Parameters:
O, 8, oversampling factor, clocks per bit; O >= 4
DW, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
SB, 1, stop bits; 1 or 2

Ports:
clk  in  1  receiver clock, nominally O x baud rate
rst_n  in  1  asynchronous active-low reset
in  in  1  UART line, asynchronous to clk, idle high
out  out  DW  received data word, LSB received first
clk_out  out  1  one-cycle high strobe when out/perr/ferr update
perr  out  1  parity error for the word on out (always 0 when PARITY=0)
ferr  out  1  framing error for the word on out (any stop bit sampled 0)

Behaviour:
- Reset (rst_n low, asynchronous):
  - out, clk_out, perr and ferr go to 0.
  - FSM goes to IDLE; all counters and the shift register clear.
  - Both synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame with no strobe.
- Input path: 2-FF synchroniser; the line is seen 2 cycles late. All logic below uses the synchronised signal s.
- Sample counter osc runs 0..O-1 per bit. Ones counter osb sums s over the bit, width clog2(O+1).
- Bit decision is made at osc == O-1: bit = (osb + s) > O/2, using integer division.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on s == 0, go to START with osc = 1 and osb = 0.
- START: decide at osc == O-1.
  - Decided 0: go to DATA with bit index 0.
  - Decided 1: glitch; return to IDLE with no strobe.
- DATA: at each decision, shift the bit into the MSB of a DW-bit shift register; data arrives LSB first.
  - After DW bits, go to PAR if PARITY != 0, else go to STOP.
- PAR: decide the parity bit. Compute pcalc = XOR(data) XOR parity bit.
  - Odd mode: error if pcalc == 0.
  - Even mode: error if pcalc == 1.
  - Latch the result internally.
- STOP: SB stop bits.
  - A non-final stop bit is a full O-sample majority decision.
  - The final stop bit is a single sample of s at osc == O/2 (cut short so the receiver can catch up to a faster transmitter).
  - ferr_int is set if any stop bit is 0.
- Output, in the cycle after the final stop-bit sample:
  - out <= shift register; perr <= latched parity error; ferr <= ferr_int.
  - clk_out = 1 for that cycle only.
  - FSM returns to IDLE in the same cycle.
- A frame with ferr = 1 is still delivered, with its strobe.
- out, perr and ferr hold until the next strobe. clk_out is 0 otherwise.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after the strobe.
- Tolerates about ±2.5% baud mismatch at O = 8.
- Latency: the strobe comes 2 (synchroniser) + 1 cycles after the final stop-bit midpoint on the pin.

Optional Feature:
Macro: UART_RX_BREAK_DETECT_EN.
- Enabled:
  - Adds output port brk (1 bit, reset 0).
  - A break is a frame where all data bits, the parity bit (if present) and the first stop bit are 0.
  - Such a frame gives a normal strobe with ferr = 1 and also sets brk = 1.
  - The FSM then waits in an extra state BRKWAIT until s has been 1 for O consecutive cycles, then returns to IDLE.
  - brk clears on the next strobe.
- Disabled:
  - No brk port and no BRKWAIT state.
  - A break frame is just a framing error, followed by normal start detection on the continued low level.

Test Plan:
1. O=4, DW=8, PARITY=0, SB=1; send 0xA5 at clk/4 -> one clk_out pulse; out = 0xA5, perr = 0, ferr = 0.
2. Idle line with a 1-cycle low glitch, then a 2-cycle low glitch -> no clk_out; FSM back in IDLE within O+3 cycles.
3. PARITY=2 (even); send 0x3C with parity bit 1 -> out = 0x3C, perr = 1. Then send 0x3C with parity bit 0 -> perr = 0.
4. SB=2; send 0x5A with the second stop bit 0 -> out = 0x5A, ferr = 1, strobe issued. Then send a correct frame 0x81 -> ferr = 0.
5. Ten back-to-back 0x55 frames, transmitter 2% fast, O=8 -> ten strobes, all out = 0x55, no errors.
6. Deassert-assert rst_n in the middle of data bit 3 -> outputs 0 immediately, no strobe. The next clean frame 0xF0 is received correctly. With UART_RX_BREAK_DETECT_EN: line held low for 20 bit times -> a single strobe with ferr = 1, brk = 1, and no further strobes until the line is high for O cycles.
